// File: rtl/debouncer_multi.sv
// debouncer_multi: N-channel input debouncer with programmable stable-cycle threshold and rise/fall pulses.
// Optional sticky event/IRQ logic is enabled by defining DEBOUNCER_IRQ_EN.
module debouncer_multi #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   bounced_i,
  input  logic [CNT_W-1:0]  thresh_i,
  output logic [N_CH-1:0]   debounced_o,
  output logic [N_CH-1:0]   rise_o,
  output logic [N_CH-1:0]   fall_o
`ifdef DEBOUNCER_IRQ_EN
  ,
  input  logic [N_CH-1:0]   irq_mask_i,
  input  logic [N_CH-1:0]   irq_clear_i,
  output logic [N_CH-1:0]   event_o,
  output logic              irq_o
`endif
);
  logic [N_CH-1:0]  s1, s2, m, hit;
  logic [CNT_W-1:0] cnt [N_CH];
  // the extra MSB keeps cnt+1 from wrapping when cnt is at its maximum
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      m[c]   = s2[c] ^ debounced_o[c];
      hit[c] = m[c] && (({1'b0, cnt[c]} + 1'b1) >= {1'b0, thresh_i});
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1          <= '0;
      s2          <= '0;
      debounced_o <= '0;
      rise_o      <= '0;
      fall_o      <= '0;
      for (int c = 0; c < N_CH; c++) cnt[c] <= '0;
    end else begin
      s1          <= bounced_i;
      s2          <= s1;
      debounced_o <= debounced_o ^ hit;
      rise_o      <= hit & s2;
      fall_o      <= hit & ~s2;
      for (int c = 0; c < N_CH; c++) cnt[c] <= (m[c] && !hit[c]) ? cnt[c] + 1'b1 : '0;
    end
  end
`ifdef DEBOUNCER_IRQ_EN
  always_ff @(posedge clock) begin
    if (reset) event_o <= '0;
    else event_o <= (event_o & ~irq_clear_i) | rise_o | fall_o;
  end
  assign irq_o = |(event_o & irq_mask_i);
`endif
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed self-checking bench for debouncer_multi (N_CH=4, CNT_W=8).
module tb_debouncer_multi;
  logic       clock = 0;
  logic       reset = 1;
  logic [3:0] bounced_i = 4'hF;
  logic [7:0] thresh_i = 8'd4;
  logic [3:0] debounced_o, rise_o, fall_o;
  int total = 0;
  int bad = 0;
`ifdef DEBOUNCER_IRQ_EN
  logic [3:0] irq_mask_i = '0;
  logic [3:0] irq_clear_i = '0;
  logic [3:0] event_o;
  logic       irq_o;
`endif

  debouncer_multi #(.N_CH(4), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .bounced_i(bounced_i),
    .thresh_i(thresh_i),
    .debounced_o(debounced_o),
    .rise_o(rise_o),
    .fall_o(fall_o)
`ifdef DEBOUNCER_IRQ_EN
    ,
    .irq_mask_i(irq_mask_i),
    .irq_clear_i(irq_clear_i),
    .event_o(event_o),
    .irq_o(irq_o)
`endif
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    step(3);
    total++;
    if ({debounced_o, rise_o, fall_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=000", {debounced_o, rise_o, fall_o});
    end
    reset = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      total++;
      if (debounced_o !== (k >= 6 ? 4'hF : 4'h0) || rise_o !== (k == 6 ? 4'hF : 4'h0) || fall_o !== 4'h0) begin
        bad++;
        $display("FAIL reset_rise k=%0d got deb=%h rise=%h fall=%h want deb=%h rise=%h fall=0", k, debounced_o, rise_o, fall_o, k >= 6 ? 4'hF : 4'h0, k == 6 ? 4'hF : 4'h0);
      end
    end
    bounced_i = 4'h0;
    for (int k = 1; k <= 7; k++) begin
      step();
      total++;
      if (debounced_o !== (k >= 6 ? 4'h0 : 4'hF) || fall_o !== (k == 6 ? 4'hF : 4'h0) || rise_o !== 4'h0) begin
        bad++;
        $display("FAIL all_fall k=%0d got deb=%h rise=%h fall=%h", k, debounced_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_glitch;
    bounced_i = 4'b0010;
    step(3);
    bounced_i = 4'b0000;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if ({debounced_o, rise_o, fall_o} !== 12'h000) begin
        bad++;
        $display("FAIL glitch k=%0d got deb=%h rise=%h fall=%h want all 0", k, debounced_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 10; k++) begin
      bounced_i = (k % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      total++;
      if ({debounced_o, rise_o, fall_o} !== 12'h000) begin
        bad++;
        $display("FAIL bounce_toggle k=%0d got deb=%h rise=%h fall=%h", k, debounced_o, rise_o, fall_o);
      end
    end
    bounced_i = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      step();
      total++;
      if (debounced_o !== (k >= 6 ? 4'b0100 : 4'b0000) || rise_o !== (k == 6 ? 4'b0100 : 4'b0000) || fall_o !== 4'b0000) begin
        bad++;
        $display("FAIL bounce_rise k=%0d got deb=%h rise=%h fall=%h", k, debounced_o, rise_o, fall_o);
      end
    end
  endtask

  task automatic test_simultaneous;
    bounced_i = 4'b1000;
    step(10);
    total++;
    if (debounced_o !== 4'b1000) begin
      bad++;
      $display("FAIL sim_setup got=%h want=8", debounced_o);
    end
    thresh_i = 8'd8;
    bounced_i = 4'b0100;
    for (int k = 1; k <= 11; k++) begin
      step();
      if (k >= 9) begin
        total++;
        if (debounced_o !== (k >= 10 ? 4'b0100 : 4'b1000) || rise_o !== (k == 10 ? 4'b0100 : 4'b0000) || fall_o !== (k == 10 ? 4'b1000 : 4'b0000)) begin
          bad++;
          $display("FAIL simultaneous k=%0d got deb=%h rise=%h fall=%h", k, debounced_o, rise_o, fall_o);
        end
      end
    end
  endtask

  task automatic test_thresholds;
    thresh_i = 8'd0;
    bounced_i = 4'b0101;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (debounced_o !== (k == 3 ? 4'b0101 : 4'b0100) || rise_o !== (k == 3 ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL t0 k=%0d got deb=%h rise=%h", k, debounced_o, rise_o);
      end
    end
    thresh_i = 8'd1;
    bounced_i = 4'b0100;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (debounced_o !== (k == 3 ? 4'b0100 : 4'b0101) || fall_o !== (k == 3 ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL t1 k=%0d got deb=%h fall=%h", k, debounced_o, fall_o);
      end
    end
    thresh_i = 8'd255;
    bounced_i = 4'b0101;
    for (int k = 1; k <= 258; k++) begin
      step();
      if (k >= 256) begin
        total++;
        if (debounced_o !== (k >= 257 ? 4'b0101 : 4'b0100) || rise_o !== (k == 257 ? 4'b0001 : 4'b0000)) begin
          bad++;
          $display("FAIL t255 k=%0d got deb=%h rise=%h", k, debounced_o, rise_o);
        end
      end
    end
    thresh_i = 8'd200;
    bounced_i = 4'b0100;
    step(51);
    total++;
    if (debounced_o !== 4'b0101 || fall_o !== 4'b0000) begin
      bad++;
      $display("FAIL t_lower_pre got deb=%h fall=%h want deb=5 fall=0", debounced_o, fall_o);
    end
    thresh_i = 8'd5;
    step();
    total++;
    if (debounced_o !== 4'b0100 || fall_o !== 4'b0001) begin
      bad++;
      $display("FAIL t_lower got deb=%h fall=%h want deb=4 fall=1", debounced_o, fall_o);
    end
  endtask

  task automatic test_reset_mid;
    thresh_i = 8'd4;
    bounced_i = 4'b0101;
    step(3);
    reset = 1;
    step();
    reset = 0;
    total++;
    if ({debounced_o, rise_o, fall_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_mid got deb=%h rise=%h fall=%h want all 0", debounced_o, rise_o, fall_o);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      total++;
      if (debounced_o !== (k >= 6 ? 4'b0101 : 4'b0000) || rise_o !== (k == 6 ? 4'b0101 : 4'b0000) || fall_o !== 4'b0000) begin
        bad++;
        $display("FAIL requalify k=%0d got deb=%h rise=%h fall=%h", k, debounced_o, rise_o, fall_o);
      end
    end
  endtask

`ifdef DEBOUNCER_IRQ_EN
  task automatic test_irq;
    total++;
    if (event_o !== 4'b0101 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_event got ev=%h irq=%b want ev=5 irq=0", event_o, irq_o);
    end
    irq_mask_i = 4'b0001;
    #1;
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL irq_mask got irq=%b want 1", irq_o);
    end
    bounced_i = 4'b0100;
    step(6);
    irq_clear_i = 4'b0001;
    step();
    irq_clear_i = 4'b0000;
    total++;
    if (event_o[0] !== 1'b1) begin
      bad++;
      $display("FAIL irq_set_wins got ev0=%b want 1", event_o[0]);
    end
    irq_clear_i = 4'b0101;
    step();
    irq_clear_i = 4'b0000;
    irq_mask_i = 4'b0000;
    total++;
    if (event_o !== 4'b0000 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear got ev=%h irq=%b want ev=0 irq=0", event_o, irq_o);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_glitch;
    test_bounce;
    test_simultaneous;
    test_thresholds;
    test_reset_mid;
`ifdef DEBOUNCER_IRQ_EN
    step();
    test_irq;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
